phantom_clock: RTL

//  CPLD stand-in for the DS1215 phantom timekeeper between the card logic and the shared RAM/ROM chip select.

---
 rtl/phantom_clock.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/phantom_clock.sv
// phantom_clock: CPLD stand-in for a DS1215-style phantom timekeeper that sits
// between the card-select stage and the shared RAM/ROM chip select.
// It watches chip-select accesses for a 64-bit recognition pattern on D0, then
// hijacks the next 64 accesses to stream a BCD real-time clock in or out.
// Optional feature macro: PHANTOM_WRITE_EN (lets a write transfer load the clock).
module phantom_clock #(
  parameter logic [63:0] PATTERN  = 64'h5CA33AC55CA33AC5,
  parameter logic [7:0]  RESET_YR = 8'h00
) (
  input  logic C7M,
  input  logic RES,
  input  logic nRAMROMCS,
  input  logic nWE,
  input  logic DI,
  input  logic TICK,
  output logic RAMROMCSgb,
  output logic DO,
  output logic DOE
);

`ifdef PHANTOM_WRITE_EN
  localparam bit WREN = 1'b1;
`else
  localparam bit WREN = 1'b0;
`endif

  typedef enum logic {MATCH, XFER} state_t;

  state_t state, state_nxt;
  logic hold;
  logic csr, start, acc_end, last, armed;
  logic nwe_s, di_s, wr, load;
  logic [5:0] cnt;
  logic [63:0] shift, shift_nxt, snap;
  logic [7:0] hs, sec, mins, hr, day, date, mon, yr;
  logic [7:0] hs_n, sec_n, mins_n, hr_n, day_n, date_n, mon_n, yr_n;

  // An access starts on the first cycle chip select is seen low and ends on the
  // first cycle it is seen high again; the two can never coincide.
  assign start   = ~nRAMROMCS & ~csr;
  assign acc_end = nRAMROMCS & csr;
  assign last    = (cnt == 6'd63);
  assign snap    = {yr, mon, date, day, hr, mins, sec, hs};

  // Reads rotate the snapshot so it is intact after 64 accesses; writes feed DI
  // into the top only when the write feature is built in.
  assign shift_nxt = {(WREN & ~nwe_s) ? di_s : shift[0], shift[63:1]};

  // The clock is overwritten only at the close of a transfer that saw a write.
  assign load = WREN & (state == XFER) & acc_end & last & (wr | ~nwe_s);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  // Year is BCD: tens*10 is congruent to tens*2 mod 4, so only the tens LSB matters.
  function automatic logic [7:0] last_date(input logic [7:0] m, input logic [7:0] y);
    logic [1:0] r;
    r = y[1:0] + {y[4], 1'b0};
    if (m == 8'h02) return (r == 2'd0) ? 8'h29 : 8'h28;
    if (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) return 8'h30;
    return 8'h31;
  endfunction

  // State register.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) state <= MATCH;
    else     state <= state_nxt;
  end

  // Next state: enter the transfer when a fully matched pattern access ends,
  // leave it when the 64th hijacked access ends.
  always_comb begin
    state_nxt = state;
    case (state)
      MATCH:   if (acc_end && armed) state_nxt = XFER;
      XFER:    if (acc_end && last)  state_nxt = MATCH;
      default: state_nxt = MATCH;
    endcase
  end

  // Outputs: while holding, RAM/ROM is deselected and reads see the shift LSB.
  always_comb begin
    hold       = (state == XFER);
    RAMROMCSgb = ~nRAMROMCS & ~hold;
    DOE        = ~nRAMROMCS & nWE & hold;
    DO         = shift[0];
  end

  // Access tracking, pattern matching and the serial shift register.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      csr   <= 1'b0;
      cnt   <= 6'd0;
      armed <= 1'b0;
      nwe_s <= 1'b1;
      di_s  <= 1'b0;
      wr    <= 1'b0;
      shift <= 64'd0;
    end else begin
      csr <= ~nRAMROMCS;
      if (start) begin
        nwe_s <= nWE;
        di_s  <= DI;
      end
      case (state)
        MATCH: begin
          if (start) begin
            if (DI == PATTERN[cnt]) begin
              cnt   <= cnt + 6'd1;
              armed <= last;
            end else begin
              cnt   <= 6'd0;
              armed <= 1'b0;
            end
          end
          if (acc_end && armed) begin
            shift <= snap;
            cnt   <= 6'd0;
            armed <= 1'b0;
            wr    <= 1'b0;
          end
        end
        XFER: begin
          if (acc_end) begin
            shift <= shift_nxt;
            cnt   <= cnt + 6'd1;
            wr    <= last ? 1'b0 : (wr | ~nwe_s);
          end
        end
        default: ;
      endcase
    end
  end

  // One 100 Hz tick rippled through the BCD fields with calendar rollover.
  always_comb begin
    hs_n   = bcd_inc(hs);
    sec_n  = sec;
    mins_n = mins;
    hr_n   = hr;
    day_n  = day;
    date_n = date;
    mon_n  = mon;
    yr_n   = yr;
    if (hs == 8'h99) begin
      hs_n  = 8'h00;
      sec_n = bcd_inc(sec);
      if (sec == 8'h59) begin
        sec_n  = 8'h00;
        mins_n = bcd_inc(mins);
        if (mins == 8'h59) begin
          mins_n = 8'h00;
          hr_n   = bcd_inc(hr);
          if (hr == 8'h23) begin
            hr_n   = 8'h00;
            day_n  = (day == 8'h07) ? 8'h01 : bcd_inc(day);
            date_n = bcd_inc(date);
            if (date == last_date(mon, yr)) begin
              date_n = 8'h01;
              mon_n  = bcd_inc(mon);
              if (mon == 8'h12) begin
                mon_n = 8'h01;
                yr_n  = (yr == 8'h99) ? 8'h00 : bcd_inc(yr);
              end
            end
          end
        end
      end
    end
  end

  // Clock registers: a transfer load takes priority over a simultaneous tick.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      {hs, sec, mins, hr} <= 32'd0;
      day  <= 8'h01;
      date <= 8'h01;
      mon  <= 8'h01;
      yr   <= RESET_YR;
    end else if (load) begin
      {yr, mon, date, day, hr, mins, sec, hs} <= shift_nxt;
    end else if (TICK) begin
      {yr, mon, date, day, hr, mins, sec, hs} <=
        {yr_n, mon_n, date_n, day_n, hr_n, mins_n, sec_n, hs_n};
    end
  end

endmodule
